// File: rtl/ahb_port_master.sv
// AHB-Lite initiator: valid/ready commands become single-beat NONSEQ transfers, one response each.
// Define AHB_PORT_MASTER_ALIGN_CHECK_EN to reject oversized or misaligned commands locally.
module ahb_port_master (
   input  logic        clock,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [2:0]  cmd_size,
   input  logic [29:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error,
   output logic [15:0] err_count,
   input  logic        io_ahb_0_hready,
   output logic [1:0]  io_ahb_0_htrans,
   output logic [2:0]  io_ahb_0_hsize,
   output logic        io_ahb_0_hwrite,
   output logic [29:0] io_ahb_0_haddr,
   output logic [31:0] io_ahb_0_hwdata,
   input  logic        io_ahb_0_hresp,
   input  logic [31:0] io_ahb_0_hrdata
);
   localparam logic [1:0] TransIdle   = 2'd0;
   localparam logic [1:0] TransNonseq = 2'd2;

   typedef enum logic [0:0] {StOk, StErr1} err_st_e;

   err_st_e     err_st_q, err_st_d;
   logic        a_valid_q, a_valid_d, a_rej_q, a_rej_d;
   logic [1:0]  htrans_q, htrans_d;
   logic [29:0] haddr_q, haddr_d;
   logic [2:0]  hsize_q, hsize_d;
   logic        hwrite_q, hwrite_d;
   logic [31:0] a_wdata_q, a_wdata_d;
   logic        d_valid_q, d_valid_d, d_write_q, d_write_d, d_rej_q, d_rej_d;
   logic [31:0] hwdata_q, hwdata_d;
   logic        rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic [15:0] err_count_q, err_count_d;

   logic cmd_rej, d_stall, err_entry, err_state, cmd_hs, a_adv, d_done;

`ifdef AHB_PORT_MASTER_ALIGN_CHECK_EN
   assign cmd_rej = (cmd_size > 3'd2) || ((cmd_size == 3'd1) && cmd_addr[0]) ||
                    ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00));
`else
   assign cmd_rej = 1'b0;
`endif

   assign d_stall   = d_valid_q & ~io_ahb_0_hready;
   // First ERROR cycle: the pending address phase must be cancelled before the slave takes it.
   assign err_entry = (err_st_q == StOk) & d_valid_q & ~d_rej_q & io_ahb_0_hresp & ~io_ahb_0_hready;
   assign err_state = (err_st_q == StErr1) | err_entry;
   assign cmd_ready = ~reset & ~err_state & (~a_valid_q | (io_ahb_0_hready & ~d_stall));
   assign cmd_hs    = cmd_valid & cmd_ready;
   // Rejected commands advance as if accepted so their response keeps its place in order.
   assign a_adv     = a_valid_q & io_ahb_0_hready & (err_st_q == StOk) &
                      ((htrans_q == TransNonseq) | a_rej_q);
   assign d_done    = d_valid_q & io_ahb_0_hready;

   always_comb begin
      err_st_d    = err_st_q;
      a_valid_d   = a_valid_q;
      a_rej_d     = a_rej_q;
      htrans_d    = htrans_q;
      haddr_d     = haddr_q;
      hsize_d     = hsize_q;
      hwrite_d    = hwrite_q;
      a_wdata_d   = a_wdata_q;
      d_valid_d   = d_valid_q;
      d_write_d   = d_write_q;
      d_rej_d     = d_rej_q;
      hwdata_d    = hwdata_q;
      err_count_d = err_count_q;

      if (a_adv) begin
         d_valid_d = 1'b1;
         d_write_d = hwrite_q;
         d_rej_d   = a_rej_q;
         if (!a_rej_q) hwdata_d = a_wdata_q;
      end else if (d_done) begin
         d_valid_d = 1'b0;
      end

      if (cmd_hs) begin
         a_valid_d = 1'b1;
         a_rej_d   = cmd_rej;
         htrans_d  = cmd_rej ? TransIdle : TransNonseq;
         haddr_d   = cmd_addr;
         hsize_d   = cmd_size;
         hwrite_d  = cmd_write;
         a_wdata_d = cmd_wdata;
      end else if (a_adv) begin
         a_valid_d = 1'b0;
         htrans_d  = TransIdle;
      end else if (err_entry) begin
         htrans_d  = TransIdle;
      end else if ((err_st_q == StErr1) && io_ahb_0_hready) begin
         htrans_d  = (a_valid_q & ~a_rej_q) ? TransNonseq : TransIdle;
      end

      if (err_entry) begin
         err_st_d = StErr1;
      end else if ((err_st_q == StErr1) && io_ahb_0_hready) begin
         err_st_d = StOk;
      end

      rsp_valid_d = d_done;
      rsp_rdata_d = (d_done & ~d_write_q & ~d_rej_q) ? io_ahb_0_hrdata : 32'h0;
      rsp_error_d = d_done & (d_rej_q | io_ahb_0_hresp);
      if (d_done && !d_rej_q && io_ahb_0_hresp && (err_count_q != 16'hFFFF)) begin
         err_count_d = err_count_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         err_st_q    <= StOk;
         a_valid_q   <= 1'b0;
         a_rej_q     <= 1'b0;
         htrans_q    <= TransIdle;
         haddr_q     <= 30'h0;
         hsize_q     <= 3'h0;
         hwrite_q    <= 1'b0;
         a_wdata_q   <= 32'h0;
         d_valid_q   <= 1'b0;
         d_write_q   <= 1'b0;
         d_rej_q     <= 1'b0;
         hwdata_q    <= 32'h0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_error_q <= 1'b0;
         err_count_q <= 16'h0;
      end else begin
         err_st_q    <= err_st_d;
         a_valid_q   <= a_valid_d;
         a_rej_q     <= a_rej_d;
         htrans_q    <= htrans_d;
         haddr_q     <= haddr_d;
         hsize_q     <= hsize_d;
         hwrite_q    <= hwrite_d;
         a_wdata_q   <= a_wdata_d;
         d_valid_q   <= d_valid_d;
         d_write_q   <= d_write_d;
         d_rej_q     <= d_rej_d;
         hwdata_q    <= hwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_error_q <= rsp_error_d;
         err_count_q <= err_count_d;
      end
   end

   assign io_ahb_0_htrans = htrans_q;
   assign io_ahb_0_haddr  = haddr_q;
   assign io_ahb_0_hsize  = hsize_q;
   assign io_ahb_0_hwrite = hwrite_q;
   assign io_ahb_0_hwdata = hwdata_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_rdata       = rsp_rdata_q;
   assign rsp_error       = rsp_error_q;
   assign err_count       = err_count_q;
endmodule
